// File: rtl/quadrature_generator_if.sv
// Command channel into the quadrature generator: one step-count command per
// valid/ready handshake, plus an abort line that stops a running command.
interface quadrature_generator_if #(
   parameter int STEP_WIDTH   = 16,
   parameter int PERIOD_WIDTH = 16
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_dir;
   logic [STEP_WIDTH-1:0]   cmd_steps;
   logic [PERIOD_WIDTH-1:0] cmd_period;
   logic                    abort;

   modport master (
      output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
      output cmd_ready
   );
endinterface

// File: rtl/quadrature_generator.sv
// Rotary-encoder emulator: emits cmd_steps quadrature edges, one every
// cmd_period clocks, and tracks a wrapping position like the counter block.
module quadrature_generator #(
   parameter int ENCODER_MAX  = 64000,
   parameter int STEP_WIDTH   = 16,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   quadrature_generator_if.slave  cmd,
   output logic                   A,
   output logic                   B,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            position
);

   localparam logic [0:0]  IDLE    = 1'b0;
   localparam logic [0:0]  RUN     = 1'b1;
   localparam logic [15:0] POS_TOP = 16'(ENCODER_MAX - 1);

   logic [0:0]              state;
   logic [1:0]              phase;
   logic                    dir_q;
   logic [STEP_WIDTH-1:0]   remaining;
   logic [PERIOD_WIDTH-1:0] period_q;
   logic [PERIOD_WIDTH-1:0] timer;
   logic                    zero_pend;
   logic [1:0]              phase_nxt;
   logic [15:0]             pos_nxt;

   assign cmd.cmd_ready = (state == IDLE);
   assign busy          = (state == RUN);

   always_comb begin
      phase_nxt = dir_q ? phase + 2'd1 : phase - 2'd1;
      pos_nxt   = position;
      if (dir_q)
         pos_nxt = (position == POS_TOP) ? '0 : position + 16'd1;
      else
         pos_nxt = (position == '0) ? POS_TOP : position - 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         phase     <= '0;
         A         <= 1'b0;
         B         <= 1'b0;
         position  <= '0;
         done      <= 1'b0;
         dir_q     <= 1'b0;
         remaining <= '0;
         period_q  <= '0;
         timer     <= '0;
         zero_pend <= 1'b0;
      end else begin
         // A zero-step command completes one cycle after its handshake.
         done      <= zero_pend;
         zero_pend <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd.cmd_valid) begin
                  dir_q     <= cmd.cmd_dir;
                  remaining <= cmd.cmd_steps;
                  if (cmd.cmd_period == '0) begin
                     period_q <= PERIOD_WIDTH'(1);
                     timer    <= '0;
                  end else begin
                     period_q <= cmd.cmd_period;
                     timer    <= cmd.cmd_period - PERIOD_WIDTH'(1);
                  end
                  if (cmd.cmd_steps != '0)
                     state <= RUN;
                  else
                     zero_pend <= 1'b1;
               end
            end
            RUN: begin
               // Abort takes priority over an edge due in the same cycle.
               if (cmd.abort) begin
                  state <= IDLE;
               end else if (timer == '0) begin
                  phase     <= phase_nxt;
                  A         <= phase_nxt[1];
                  B         <= phase_nxt[1] ^ phase_nxt[0];
                  position  <= pos_nxt;
                  remaining <= remaining - STEP_WIDTH'(1);
                  timer     <= period_q - PERIOD_WIDTH'(1);
                  if (remaining == STEP_WIDTH'(1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end else begin
                  timer <= timer - PERIOD_WIDTH'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quadrature_generator.sv
// Bench for quadrature_generator: commands are checked cycle by cycle against
// an arithmetic model of phase count, wrapped position and handshake timing.
module tb_quadrature_generator;
   localparam int MAX = 64000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   quadrature_generator_if #(.STEP_WIDTH(16), .PERIOD_WIDTH(16)) bus ();

   logic        A, B, busy, done;
   logic [15:0] position;
   logic [20:0] actv;

   quadrature_generator #(
      .ENCODER_MAX (MAX),
      .STEP_WIDTH  (16),
      .PERIOD_WIDTH(16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .cmd     (bus),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .position(position)
   );

   assign actv = {A, B, busy, done, bus.cmd_ready, position};

   int tests = 0;
   int fails = 0;
   int m_phase = 0;   // number of forward edges modulo 4
   int m_pos   = 0;

   function automatic logic [1:0] ab_of(input int p);
      case (p)
         0: return 2'b00;
         1: return 2'b01;
         2: return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   // Expected {A,B,busy,done,cmd_ready,position} from the model state.
   function automatic logic [20:0] expv(input bit bz, input bit dn, input bit rd);
      return {ab_of(m_phase), bz, dn, rd, 16'(m_pos)};
   endfunction

   function automatic void step_model(input bit dir);
      if (dir) begin
         m_phase = (m_phase + 1) % 4;
         m_pos   = (m_pos + 1) % MAX;
      end else begin
         m_phase = (m_phase + 3) % 4;
         m_pos   = (m_pos + MAX - 1) % MAX;
      end
   endfunction

   // Issues one command at the next edge and checks every cycle until it ends.
   // abort_cyc: cycle after the handshake at which abort is sampled (-1 = none).
   // hold: leave cmd_valid high so the following command is taken back to back.
   task automatic run_cmd(input string name, input bit dir, input int steps,
                          input int period, input int abort_cyc, input bit hold);
      int pe, total;
      logic [20:0] e;
      pe    = (period == 0) ? 1 : period;
      total = (steps == 0) ? 1 : steps * pe;
      bus.cmd_valid  = 1'b1;
      bus.cmd_dir    = dir;
      bus.cmd_steps  = 16'(steps);
      bus.cmd_period = 16'(period);
      @(posedge clk); #1;
      bus.cmd_valid = hold;
      e = expv(steps != 0, 1'b0, steps == 0);
      tests++;
      if (actv !== e) begin
         fails++;
         $display("FAIL %s handshake: got %h expected %h", name, actv, e);
      end
      for (int j = 1; j <= total; j++) begin
         bit ab, last;
         // Inputs other than abort must be ignored while running.
         if (!hold && steps != 0) begin
            bus.cmd_valid  = 1'($urandom);
            bus.cmd_dir    = 1'($urandom);
            bus.cmd_steps  = 16'($urandom);
            bus.cmd_period = 16'($urandom);
         end
         ab = (j == abort_cyc);
         if (ab) bus.abort = 1'b1;
         @(posedge clk); #1;
         bus.abort = 1'b0;
         if (!hold) bus.cmd_valid = 1'b0;
         if (ab) begin
            e = expv(1'b0, 1'b0, 1'b1);
         end else if (steps == 0) begin
            e = expv(1'b0, 1'b1, 1'b1);
         end else begin
            if (j % pe == 0) step_model(dir);
            last = (j == total);
            e = expv(!last, last, last);
         end
         tests++;
         if (actv !== e) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, j, actv, e);
         end
         if (ab) break;
      end
      bus.cmd_valid = hold;
   endtask

   task automatic test_power_on;
      #1;
      tests++;
      if (actv !== expv(1'b0, 1'b0, 1'b1)) begin
         fails++;
         $display("FAIL power_on_reset: got %h expected %h", actv, expv(1'b0, 1'b0, 1'b1));
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_backward_wrap;
      run_cmd("backward_wrap", 1'b0, 3, 1, -1, 1'b0);
   endtask

   task automatic test_forward;
      run_cmd("forward8", 1'b1, 8, 1, -1, 1'b0);
   endtask

   task automatic test_period;
      run_cmd("period5", 1'b1, 2, 5, -1, 1'b0);
      run_cmd("period0", 1'b0, 1, 0, -1, 1'b0);
   endtask

   task automatic test_abort;
      run_cmd("abort", 1'b1, 10, 4, 9, 1'b0);
      run_cmd("abort_follow", 1'b1, 3, 1, -1, 1'b0);
      run_cmd("abort_on_expiry", 1'b0, 5, 3, 6, 1'b0);
      run_cmd("abort_follow2", 1'b0, 2, 2, -1, 1'b0);
   endtask

   task automatic test_back_to_back;
      run_cmd("zero_steps", 1'b1, 0, 3, -1, 1'b0);
      run_cmd("b2b_first", 1'b1, 2, 1, -1, 1'b1);
      run_cmd("b2b_second", 1'b1, 2, 1, -1, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 24; i++) begin
         int st, pr, pe, ac;
         bit hd;
         st = int'($urandom_range(0, 12));
         pr = int'($urandom_range(0, 4));
         pe = (pr == 0) ? 1 : pr;
         ac = (st != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, st * pe)) : -1;
         hd = (st != 0) && (i != 23) && ($urandom_range(0, 1) == 1);
         run_cmd("random", 1'($urandom), st, pr, ac, hd);
      end
   endtask

   task automatic test_reset;
      bus.cmd_valid  = 1'b1;
      bus.cmd_dir    = 1'b1;
      bus.cmd_steps  = 16'd10;
      bus.cmd_period = 16'd1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      m_phase = 0;
      m_pos   = 0;
      tests++;
      if (actv !== expv(1'b0, 1'b0, 1'b1)) begin
         fails++;
         $display("FAIL reset_mid_run: got %h expected %h", actv, expv(1'b0, 1'b0, 1'b1));
      end
      @(posedge clk); #1;
      rst = 1'b1;
      run_cmd("after_reset", 1'b1, 3, 2, -1, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_dir    = 1'b0;
      bus.cmd_steps  = '0;
      bus.cmd_period = '0;
      bus.abort      = 1'b0;
      test_power_on();
      test_backward_wrap();
      test_forward();
      test_period();
      test_abort();
      test_back_to_back();
      test_random();
      test_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
